// File: rtl/aes_pkg.sv
// aes_pkg: shared AES encodings, widths and the byte S-box table
package aes_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, KEY = 2'd1, DATA = 2'd2} state_t;
  localparam int NB = 4;
  localparam int WORD_W = 32;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction
endpackage

// File: rtl/sbox_byte.sv
// sbox_byte: single combinational AES forward S-box
module sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox(a);
endmodule

// File: rtl/sbox_word.sv
// sbox_word: 32-bit S-box lane, byte n maps bits [8n+7:8n] in place
module sbox_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] y
);
  for (genvar n = 0; n < 4; n++) begin : g_byte
    sbox_byte u_byte (.a(a[8*n +: 8]), .y(y[8*n +: 8]));
  end
endmodule

// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: round-robin time-sharing of one S-box lane between SubWord and SubBytes
module aes_sbox_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         k_req,
  input  logic [31:0]  k_word,
  output logic         k_gnt,
  output logic         k_done,
  output logic [31:0]  k_result,
  input  logic         d_req,
  input  logic [127:0] d_state,
  output logic         d_gnt,
  output logic         d_done,
  output logic [127:0] d_result,
  output logic         busy
);
  state_t state, state_nx;
  logic [1:0] col;
  logic prio;
  logic [WORD_W-1:0] k_op, lane_in, lane_out;
  logic [NB-1:0][WORD_W-1:0] d_op, d_res;
  logic k_acc, d_acc;
  assign k_acc = k_req & k_gnt;
  assign d_acc = d_req & d_gnt;
  // column c lives in word NB-1-c, i.e. ~col, so column 0 is the MSW
  assign lane_in = state == KEY ? k_op : d_op[~col];
  assign d_result = d_res;
  sbox_word u_lane (.a(lane_in), .y(lane_out));
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: KEY is a single pass, DATA runs four column beats
  always_comb
    state_nx = state == IDLE ? (k_acc ? KEY : d_acc ? DATA : IDLE) :
               (state == DATA && col != 2'd3) ? DATA : IDLE;
  // grants only in IDLE; prio breaks ties, a lone requester always wins
  always_comb begin
    k_gnt = state == IDLE && k_req && (!d_req || !prio);
    d_gnt = state == IDLE && d_req && (!k_req || prio);
    busy = state != IDLE;
  end
  // operands, beat counter, priority and registered results
  always_ff @(posedge clk)
    if (rst) begin
      col <= 2'd0;
      prio <= 1'b0;
      k_op <= '0;
      d_op <= '0;
      k_result <= '0;
      d_res <= '0;
      k_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      col <= state == DATA ? col + 2'd1 : 2'd0;
      prio <= k_acc ? 1'b1 : d_acc ? 1'b0 : prio;
      if (k_acc) k_op <= k_word;
      if (d_acc) d_op <= d_state;
      if (state == KEY) k_result <= lane_out;
      if (state == DATA) d_res[~col] <= lane_out;
      k_done <= state == KEY;
      d_done <= state == DATA && col == 2'd3;
    end
endmodule

// File: tb/tb_aes_sbox_sched.sv
// tb_aes_sbox_sched: directed vectors with a done-driven scoreboard
module tb_aes_sbox_sched;
  logic clk = 0, rst = 1, k_req = 0, d_req = 0;
  logic [31:0] k_word = '0, k_exp = '0;
  logic [127:0] d_state = '0, d_exp = '0;
  logic k_gnt, k_done, d_gnt, d_done, busy;
  logic [31:0] k_result;
  logic [127:0] d_result;
  typedef struct {logic [127:0] v; int due;} exp_t;
  exp_t kq[$], dq[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  localparam logic [127:0] V0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R0 = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] V2 = 128'h00010203102030ffa5a5a5a553c00040;
  localparam logic [127:0] R2 = 128'h637c777bcab7041606060606edba6309;
  logic [31:0] bw [3] = '{32'ha5a5a5a5, 32'hffffffff, 32'h53c00040};
  logic [31:0] be [3] = '{32'h06060606, 32'h16161616, 32'hedba6309};

  aes_sbox_sched dut (
    .clk(clk), .rst(rst),
    .k_req(k_req), .k_word(k_word), .k_gnt(k_gnt), .k_done(k_done), .k_result(k_result),
    .d_req(d_req), .d_state(d_state), .d_gnt(d_gnt), .d_done(d_done), .d_result(d_result),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && kq.size() == 0 && dq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle timeout: busy %0b kq %0d dq %0d", busy, kq.size(), dq.size());
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (k_req && k_gnt) kq.push_back('{v: {96'd0, k_exp}, due: cyc + 2});
      if (d_req && d_gnt) dq.push_back('{v: d_exp, due: cyc + 5});
    end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (k_done) begin
        if (kq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL k_done unexpected: k_result %h", k_result);
        end else begin
          e = kq.pop_front();
          chk("k_result", {96'd0, k_result}, e.v);
          chk("k_done cycle", cyc, e.due);
        end
      end
      if (d_done) begin
        if (dq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d_done unexpected: d_result %h", d_result);
        end else begin
          e = dq.pop_front();
          chk("d_result", d_result, e.v);
          chk("d_done cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst k_done", k_done, 0);
    chk("rst d_done", d_done, 0);
    chk("rst k_result", k_result, 0);
    chk("rst d_result", d_result, 0);
    chk("rst k_gnt", k_gnt, 0);
    tick; rst = 0;
    // lone key request
    k_word = 32'h00010203; k_exp = 32'h637c777b; k_req = 1;
    @(negedge clk); chk("k lone gnt", k_gnt, 1); chk("k idle busy", busy, 0);
    tick; k_req = 0;
    @(negedge clk); chk("busy in KEY", busy, 1);
    tick;
    @(negedge clk); chk("busy k done cycle", busy, 0); chk("k_done pulse", k_done, 1);
    tick;
    @(negedge clk); chk("k_done one cycle", k_done, 0); chk("k_result held", k_result, 32'h637c777b);
    // lone data request
    tick; d_state = V0; d_exp = R0; d_req = 1;
    @(negedge clk); chk("d lone gnt", d_gnt, 1);
    tick; d_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("busy in DATA", busy, 1);
      tick;
    end
    @(negedge clk); chk("busy d done cycle", busy, 0); chk("d_done pulse", d_done, 1);
    // simultaneous requests after reset
    tick; rst = 1;
    tick; rst = 0;
    @(negedge clk); chk("rst clears d_result", d_result, 0);
    tick;
    k_word = 32'h102030ff; k_exp = 32'hcab70416; k_req = 1;
    d_state = V2; d_exp = R2; d_req = 1;
    @(negedge clk); chk("pair k first", k_gnt, 1); chk("pair d held", d_gnt, 0);
    tick; k_req = 0;
    @(negedge clk); chk("d gnt in KEY", d_gnt, 0);
    tick; k_word = 32'ha5a5a5a5; k_exp = 32'h06060606; k_req = 1;
    @(negedge clk); chk("pair2 d first", d_gnt, 1); chk("pair2 k held", k_gnt, 0); chk("k_done at d gnt", k_done, 1);
    tick; d_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("k waits for DATA", k_gnt, 0);
      tick;
    end
    @(negedge clk); chk("k gnt after d", k_gnt, 1); chk("d_done with k gnt", d_done, 1);
    tick; k_req = 0;
    wait_idle;
    // back-to-back key requests, k_req held high
    tick; k_word = bw[0]; k_exp = be[0]; k_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("b2b gnt", k_gnt, 1);
      if (i > 0) chk("b2b done with accept", k_done, 1);
      tick;
      if (i < 2) begin
        k_word = bw[i+1]; k_exp = be[i+1];
      end else k_req = 0;
      @(negedge clk); chk("b2b gnt in KEY", k_gnt, 0);
      tick;
    end
    wait_idle;
    // reset during DATA beat 2
    tick; d_state = V0; d_exp = R0; d_req = 1;
    @(negedge clk); chk("abort d gnt", d_gnt, 1);
    tick; d_req = 0;
    tick;
    tick; rst = 1;
    @(negedge clk); chk("partial cols 0-1", d_result[127:64], R0[127:64]);
    tick; rst = 0; dq.delete();
    @(negedge clk); chk("abort busy", busy, 0); chk("abort d_result", d_result, 0); chk("abort no done", d_done, 0);
    tick;
    @(negedge clk); chk("abort no late done", d_done, 0);
    tick; d_state = '0; d_exp = {16{8'h63}}; d_req = 1;
    @(negedge clk); chk("fresh d gnt", d_gnt, 1);
    tick; d_req = 0;
    wait_idle;
    // data request while KEY is busy
    tick; k_word = 32'h00010203; k_exp = 32'h637c777b; k_req = 1;
    @(negedge clk); chk("busy test k gnt", k_gnt, 1);
    tick; k_req = 0; d_req = 1; d_state = '1;
    @(negedge clk); chk("d while busy", d_gnt, 0);
    tick; d_state = V2; d_exp = R2;
    @(negedge clk); chk("d gnt back in IDLE", d_gnt, 1);
    tick; d_req = 0; d_state = '1;
    wait_idle;
    chk("kq drained", kq.size(), 0);
    chk("dq drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
